// File: rtl/display_pkg.sv
// Shared definitions for the text display: scheduler states, character-RAM
// address layout and the {line,col} address helper.
package display_pkg;

    localparam int LINE_W = 7;
    localparam int COL_W  = 7;
    localparam int ADDR_W = LINE_W + COL_W;

    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LINE  = 2'd1,
        ST_DONE  = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    function automatic logic [ADDR_W-1:0] char_addr(input logic [LINE_W-1:0] line,
                                                    input logic [COL_W-1:0]  col);
        return {line, col};
    endfunction

endpackage

// File: rtl/char_write_scheduler_if.sv
// Line-producer handshake plus character-RAM write port of the scheduler.
// The scheduler side is master; producers and RAM together form the slave side.
interface char_write_scheduler_if
    import display_pkg::*;
#(
    parameter int NUM_SRC = 4
) ();

    logic [NUM_SRC-1:0]        req;
    logic [LINE_W*NUM_SRC-1:0] src_line;
    logic                      clear;
    logic [NUM_SRC-1:0]        grant;
    logic [NUM_SRC-1:0]        done;
    logic [COL_W-1:0]          src_col;
    logic [7:0]                src_char;
    logic [ADDR_W-1:0]         wr_addr;
    logic [7:0]                wr_data;
    logic                      wr_en;
    logic                      busy;

    modport master (
        input  req, src_line, clear, src_char,
        output grant, done, src_col, wr_addr, wr_data, wr_en, busy
    );

    modport slave (
        output req, src_line, clear, src_char,
        input  grant, done, src_col, wr_addr, wr_data, wr_en, busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or above rr_ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_SRC-1:0] winner,
    output logic [IDX_W-1:0]   winner_idx,
    output logic               valid
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        valid      = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            int k;
            k = (int'(rr_ptr) + i) % NUM_SRC;
            if (!valid && req[k]) begin
                valid      = 1'b1;
                winner_idx = IDX_W'(k);
                winner[k]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/char_write_scheduler.sv
// Sole owner of the character-RAM write port: writes one granted text line per
// grant, column by column, and blanks the whole screen after reset or on clear.
module char_write_scheduler
    import display_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int LINE_LEN  = 24,
    parameter int NUM_LINES = 16
) (
    input logic                    pixel_clock,
    input logic                    reset,
    char_write_scheduler_if.master bus
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(LINE_LEN - 1);
    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(NUM_LINES - 1);
    localparam logic [IDX_W-1:0]  LAST_SRC  = IDX_W'(NUM_SRC - 1);

    state_t state, next_state;

    logic                clear_pend;
    logic [IDX_W-1:0]    rr_ptr, rr_d;
    logic [IDX_W-1:0]    win_q, win_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [NUM_SRC-1:0]  grant_q, grant_d;
    logic [NUM_SRC-1:0]  done_q, done_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [7:0]          wr_data_q, wr_data_d;

    logic [NUM_SRC-1:0]  arb_winner;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_valid;
    logic                last_col, last_line;

    rr_arbiter #(.NUM_SRC(NUM_SRC), .IDX_W(IDX_W)) u_arb (
        .req        (bus.req),
        .rr_ptr     (rr_ptr),
        .winner     (arb_winner),
        .winner_idx (arb_idx),
        .valid      (arb_valid)
    );

    assign last_col  = (col_q == LAST_COL);
    assign last_line = (line_q == LAST_LINE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge pixel_clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (clear_pend)             next_state = ST_CLEAR;
                      else if (arb_valid)         next_state = ST_LINE;
            ST_LINE:  if (last_col)               next_state = ST_DONE;
            ST_DONE:                              next_state = ST_IDLE;
            ST_CLEAR: if (last_col && last_line)  next_state = ST_IDLE;
            default:                              next_state = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and counters.
    always_comb begin
        grant_d   = grant_q;
        done_d    = '0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        col_d     = col_q;
        line_d    = line_q;
        win_d     = win_q;
        rr_d      = rr_ptr;
        case (state)
            ST_IDLE: begin
                if (clear_pend) begin
                    col_d  = '0;
                    line_d = '0;
                end else if (arb_valid) begin
                    grant_d = arb_winner;
                    win_d   = arb_idx;
                    line_d  = bus.src_line[LINE_W*arb_idx +: LINE_W];
                    col_d   = '0;
                end
            end
            ST_LINE: begin
                wr_en_d   = 1'b1;
                wr_data_d = bus.src_char;
                wr_addr_d = char_addr(line_q, col_q);
                col_d     = last_col ? '0 : col_q + 1'b1;
            end
            ST_DONE: begin
                grant_d = '0;
                done_d  = grant_q;
                rr_d    = (win_q == LAST_SRC) ? '0 : win_q + 1'b1;
            end
            ST_CLEAR: begin
                wr_en_d   = 1'b1;
                wr_data_d = ASCII_SPACE;
                wr_addr_d = char_addr(line_q, col_q);
                if (last_col) begin
                    col_d  = '0;
                    line_d = last_line ? '0 : line_q + 1'b1;
                end else begin
                    col_d  = col_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // clear_pend resets to 1 so the screen is blanked right after reset.
    always_ff @(posedge pixel_clock or negedge reset) begin
        if (!reset) begin
            grant_q    <= '0;
            done_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            col_q      <= '0;
            line_q     <= '0;
            win_q      <= '0;
            rr_ptr     <= '0;
            clear_pend <= 1'b1;
        end else begin
            grant_q    <= grant_d;
            done_q     <= done_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            col_q      <= col_d;
            line_q     <= line_d;
            win_q      <= win_d;
            rr_ptr     <= rr_d;
            clear_pend <= bus.clear | (clear_pend & (state != ST_IDLE));
        end
    end

    assign bus.grant   = grant_q;
    assign bus.done    = done_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.src_col = col_q;
    assign bus.busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_char_write_scheduler.sv
// Self-checking bench for char_write_scheduler: a write scoreboard fed when
// requests are driven, a table of single-line grants and multi-cycle corner sequences.
module tb_char_write_scheduler;

    localparam int NUM_SRC   = 4;
    localparam int LINE_LEN  = 24;
    localparam int NUM_LINES = 16;
    localparam int BLANKS    = NUM_LINES * LINE_LEN;

    typedef struct {
        logic [13:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct {
        logic [3:0]  req;
        logic [27:0] lines;
        logic [3:0]  exp_grant;
        logic [6:0]  exp_line;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    wr_t  exp_q[$];
    vec_t vecs[7];

    always #5 clk = ~clk;

    char_write_scheduler_if #(.NUM_SRC(NUM_SRC)) bus ();

    char_write_scheduler #(
        .NUM_SRC   (NUM_SRC),
        .LINE_LEN  (LINE_LEN),
        .NUM_LINES (NUM_LINES)
    ) dut (
        .pixel_clock (clk),
        .reset       (rst_n),
        .bus         (bus)
    );

    // Every producer answers with 'A' + column.
    always_comb bus.src_char = 8'h41 + {1'b0, bus.src_col};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_line(input logic [6:0] line, input int ncols);
        for (int c = 0; c < ncols; c++) begin
            wr_t w;
            w.addr = {line, 7'(c)};
            w.data = 8'h41 + 8'(c);
            exp_q.push_back(w);
        end
    endtask

    task automatic push_blank();
        for (int l = 0; l < NUM_LINES; l++)
            for (int c = 0; c < LINE_LEN; c++) begin
                wr_t w;
                w.addr = {7'(l), 7'(c)};
                w.data = 8'h20;
                exp_q.push_back(w);
            end
    endtask

    task automatic wait_grant(input string name, input logic [3:0] exp, input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus.grant != 4'b0) break;
        end
        check(name, 32'(bus.grant), 32'(exp));
    endtask

    task automatic wait_done(input string name, input logic [3:0] exp, output int cycles);
        cycles = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            cycles++;
            if (bus.done != 4'b0) break;
        end
        check(name, 32'(bus.done), 32'(exp));
    endtask

    task automatic wait_col(input string name, input logic [6:0] col);
        for (int i = 0; i < 60; i++) begin
            if (bus.grant != 4'b0 && bus.src_col == col) break;
            @(negedge clk);
        end
        check(name, 32'(bus.src_col), 32'(col));
    endtask

    task automatic wait_drain(input string name, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard and structural invariants, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("grant_onehot", 32'($onehot0(bus.grant)), 32'd1);
            if (bus.grant != 4'b0) check("busy_with_grant", 32'(bus.busy), 32'd1);
            if (bus.wr_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'(bus.wr_addr), 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
                    check("wr_data", 32'(bus.wr_data), 32'(e.data));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;

        vecs[0] = '{4'b0100, {7'd9, 7'd3, 7'd1,  7'd7}, 4'b0100, 7'd3};
        vecs[1] = '{4'b0001, {7'd9, 7'd3, 7'd1,  7'd7}, 4'b0001, 7'd7};
        vecs[2] = '{4'b1001, {7'd9, 7'd3, 7'd1,  7'd7}, 4'b1000, 7'd9};
        vecs[3] = '{4'b0011, {7'd9, 7'd3, 7'd15, 7'd0}, 4'b0001, 7'd0};
        vecs[4] = '{4'b0011, {7'd9, 7'd3, 7'd15, 7'd0}, 4'b0010, 7'd15};
        vecs[5] = '{4'b1111, {7'd9, 7'd3, 7'd1,  7'd7}, 4'b0100, 7'd3};
        vecs[6] = '{4'b1000, {7'd9, 7'd3, 7'd1,  7'd7}, 4'b1000, 7'd9};

        rst_n        = 1'b0;
        bus.req      = '0;
        bus.src_line = '0;
        bus.clear    = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_grant",   32'(bus.grant),   32'd0);
        check("rst_done",    32'(bus.done),    32'd0);
        check("rst_wr_en",   32'(bus.wr_en),   32'd0);
        check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        check("rst_wr_data", 32'(bus.wr_data), 32'd0);
        check("rst_src_col", 32'(bus.src_col), 32'd0);
        check("rst_busy",    32'(bus.busy),    32'd0);

        // Power-up blank: one unbroken run of space writes, then idle.
        push_blank();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.wr_en) break;
        end
        n = 0;
        while (bus.wr_en === 1'b1 && n < BLANKS + 10) begin
            n++;
            @(negedge clk);
        end
        check("blank_run_len", 32'(n), 32'(BLANKS));
        check("blank_then_idle", 32'(bus.busy), 32'd0);
        check("blank_all_written", 32'(exp_q.size()), 32'd0);

        // Table: one request pattern per row, round robin carried between rows.
        for (int i = 0; i < 7; i++) begin
            bus.src_line = vecs[i].lines;
            bus.req      = vecs[i].req;
            push_line(vecs[i].exp_line, LINE_LEN);
            wait_grant($sformatf("vec%0d_grant", i), vecs[i].exp_grant, 100);
            wait_done($sformatf("vec%0d_done", i), vecs[i].exp_grant, n);
            check($sformatf("vec%0d_done_latency", i), 32'(n), 32'(LINE_LEN + 1));
            bus.req = '0;
            @(negedge clk);
            check($sformatf("vec%0d_done_once", i), 32'(bus.done), 32'd0);
            wait_drain($sformatf("vec%0d_drain", i), 10);
        end

        // All four requesting, each dropping on its done: order 0..3, twice.
        for (int round = 0; round < 2; round++) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                bus.src_line[7*k +: 7] = 7'(10 + 2*round + k);
                push_line(7'(10 + 2*round + k), LINE_LEN);
            end
            bus.req = 4'b1111;
            for (int k = 0; k < NUM_SRC; k++) begin
                wait_grant($sformatf("rr%0d_grant%0d", round, k), 4'(1 << k), 100);
                wait_done($sformatf("rr%0d_done%0d", round, k), 4'(1 << k), n);
                bus.req[k] = 1'b0;
            end
            wait_drain($sformatf("rr%0d_drain", round), 10);
        end

        // Clear mid-line: the line completes, blanking follows, then the pending request.
        bus.src_line[13:7] = 7'd5;
        bus.req            = 4'b0010;
        push_line(7'd5, LINE_LEN);
        push_blank();
        push_line(7'd6, LINE_LEN);
        wait_grant("clr_grant", 4'b0010, 100);
        bus.src_line[20:14] = 7'd6;
        bus.req[2]          = 1'b1;
        wait_col("clr_col10", 7'd10);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        wait_done("clr_done", 4'b0010, n);
        bus.req[1] = 1'b0;
        wait_grant("clr_next_grant", 4'b0100, 500);
        check("clr_blank_before_grant", 32'(exp_q.size()), 32'(LINE_LEN));
        wait_done("clr_next_done", 4'b0100, n);
        bus.req = '0;
        wait_drain("clr_drain", 10);

        // Reset mid-line: outputs drop at once, blank first, then the line from column 0.
        bus.src_line[6:0] = 7'd8;
        bus.req           = 4'b0001;
        push_line(7'd8, 12);
        push_blank();
        push_line(7'd8, LINE_LEN);
        wait_grant("rst_mid_grant", 4'b0001, 100);
        wait_col("rst_mid_col12", 7'd12);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_wr_en", 32'(bus.wr_en), 32'd0);
        check("rst_mid_grant_low", 32'(bus.grant), 32'd0);
        check("rst_mid_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_grant("rst_regrant", 4'b0001, 500);
        check("rst_blank_before_grant", 32'(exp_q.size()), 32'(LINE_LEN));
        wait_done("rst_redone", 4'b0001, n);
        bus.req = '0;
        wait_drain("rst_drain", 10);

        // Request dropped and line changed mid-write: original line still completes.
        bus.src_line[13:7] = 7'd2;
        bus.req            = 4'b0010;
        push_line(7'd2, LINE_LEN);
        wait_grant("drop_grant", 4'b0010, 100);
        wait_col("drop_col3", 7'd3);
        bus.req[1]         = 1'b0;
        bus.src_line[13:7] = 7'd9;
        wait_done("drop_done", 4'b0010, n);
        wait_drain("drop_drain", 10);
        repeat (3) @(negedge clk);
        check("final_idle", 32'(bus.busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
